// File: rtl/sliding_window_ctrl.sv
// Sliding-window controller: tracks pixel position and drives the window
// datapath shift enable and window valid/ready handshake.
module sliding_window_ctrl #(
  parameter int WINDOW_WIDTH    = 3,
  parameter int WINDOW_HEIGHT   = 3,
  parameter int PIXLES_PER_LINE = 4,
  parameter int LINES_PER_FRAME = 4,
  localparam int CW = (PIXLES_PER_LINE > 1) ?
                      $clog2(PIXLES_PER_LINE) : 1,
  localparam int RW = (LINES_PER_FRAME > 1) ?
                      $clog2(LINES_PER_FRAME) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  output logic          busy,
  input  logic          in_valid,
  output logic          in_ready,
  output logic          win_en,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [CW-1:0] out_col,
  output logic [RW-1:0] out_row,
  output logic          out_last,
  output logic          frame_done
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  localparam logic [CW-1:0] COL_LAST = CW'(PIXLES_PER_LINE - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(LINES_PER_FRAME - 1);
  localparam logic [CW-1:0] COL_MIN  = CW'(WINDOW_WIDTH - 1);
  localparam logic [RW-1:0] ROW_MIN  = RW'(WINDOW_HEIGHT - 1);

  logic [1:0]    state;
  logic [CW-1:0] col;
  logic [RW-1:0] row;

  logic col_end;
  logic row_end;
  logic frame_end;
  logic qual;
  logic out_hs;
  logic done_hs;

  // Position decode and handshake qualifiers
  always_comb begin
    col_end   = (col == COL_LAST);
    row_end   = (row == ROW_LAST);
    frame_end = col_end && row_end;
    qual      = (col >= COL_MIN) && (row >= ROW_MIN);
    out_hs    = out_valid && out_ready;
    done_hs   = out_hs && out_last;
    busy      = (state != S_IDLE);
    in_ready  = (state == S_RUN) &&
                (!out_valid || out_ready);
    win_en    = in_valid && in_ready;
  end

  // Frame state machine
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      unique case (state)
        S_IDLE:  if (start) state <= S_RUN;
        S_RUN:   if (win_en && frame_end)
                   state <= S_DRAIN;
        S_DRAIN: if (done_hs) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Pixel position counters; they freeze on the final pixel
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col <= '0;
      row <= '0;
    end else if (state == S_IDLE && start) begin
      col <= '0;
      row <= '0;
    end else if (win_en && !frame_end) begin
      if (col_end) begin
        col <= '0;
        row <= row + RW'(1);
      end else begin
        col <= col + CW'(1);
      end
    end
  end

  // Presented-window register: loads on shift, clears on consume
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_row   <= '0;
      out_col   <= '0;
    end else if (win_en) begin
      out_valid <= qual;
      out_last  <= qual && frame_end;
      out_row   <= row;
      out_col   <= col;
    end else if (out_hs) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end
  end

  // Completion pulse, one cycle after the final window is consumed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_done <= 1'b0;
    end else begin
      frame_done <= done_hs;
    end
  end

endmodule

// File: tb/tb_sliding_window_ctrl.sv
// Scoreboard bench for sliding_window_ctrl: default geometry
// plus a 2x2 window over a 5x3 frame.
module tb_sliding_window_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic start = 0, in_valid = 0, out_ready = 0;
  logic busy, in_ready, win_en, out_valid;
  logic out_last, frame_done;
  logic [1:0] out_col, out_row;

  logic start2 = 0, in_valid2 = 0, out_ready2 = 0;
  logic busy2, in_ready2, win_en2, out_valid2;
  logic out_last2, frame_done2;
  logic [2:0] out_col2;
  logic [1:0] out_row2;

  int checks = 0;
  int errors = 0;
  int wins1 = 0;
  int wins2 = 0;

  typedef struct {
    int r;
    int c;
    bit l;
  } win_t;

  win_t q1[$];
  win_t q2[$];
  win_t e1, e2;

  always #5 clk = ~clk;

  sliding_window_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .busy(busy), .in_valid(in_valid),
    .in_ready(in_ready), .win_en(win_en),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_col(out_col), .out_row(out_row),
    .out_last(out_last), .frame_done(frame_done)
  );

  sliding_window_ctrl #(
    .WINDOW_WIDTH(2), .WINDOW_HEIGHT(2),
    .PIXLES_PER_LINE(5), .LINES_PER_FRAME(3)
  ) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2),
    .busy(busy2), .in_valid(in_valid2),
    .in_ready(in_ready2), .win_en(win_en2),
    .out_valid(out_valid2), .out_ready(out_ready2),
    .out_col(out_col2), .out_row(out_row2),
    .out_last(out_last2), .frame_done(frame_done2)
  );

  task automatic chk(input string n,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d",
               n, act, exp);
    end
  endtask

  task automatic push1(input int r, input int c,
                       input bit l);
    q1.push_back('{r, c, l});
  endtask

  task automatic push2(input int r, input int c,
                       input bit l);
    q2.push_back('{r, c, l});
  endtask

  task automatic push_default();
    push1(2, 2, 0);
    push1(2, 3, 0);
    push1(3, 2, 0);
    push1(3, 3, 1);
  endtask

  // Monitor for the default instance
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      wins1++;
      if (q1.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL win1_extra: got (%0d,%0d), expected none",
                 out_row, out_col);
      end else begin
        e1 = q1.pop_front();
        chk("win1_row", 32'(out_row), e1.r);
        chk("win1_col", 32'(out_col), e1.c);
        chk("win1_last", 32'(out_last), 32'(e1.l));
      end
    end
  end

  // Monitor for the 2x2 / 5x3 instance
  always @(negedge clk) begin
    if (rst_n && out_valid2 && out_ready2) begin
      wins2++;
      if (q2.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL win2_extra: got (%0d,%0d), expected none",
                 out_row2, out_col2);
      end else begin
        e2 = q2.pop_front();
        chk("win2_row", 32'(out_row2), e2.r);
        chk("win2_col", 32'(out_col2), e2.c);
        chk("win2_last", 32'(out_last2), 32'(e2.l));
      end
    end
  end

  task automatic start_frame();
    @(posedge clk); #1;
    start = 1;
  endtask

  // mode 0: stream, 1: stall at first window,
  // 2: toggle in_valid, 3: start held + drain stall
  task automatic run_frame(input int mode,
                           output int acc,
                           output int cycs);
    int stall_left;
    bit stalled;
    int hs_last;
    bit done;
    stall_left = 0;
    stalled = 0;
    hs_last = -10;
    done = 0;
    acc = 0;
    cycs = -1;
    for (int cyc = 0; cyc < 200 && !done; cyc++) begin
      @(posedge clk); #1;
      if (frame_done) begin
        done = 1;
        cycs = cyc;
        chk("fd_after_last_hs", cyc - hs_last, 1);
        chk("fd_idle", 32'(busy), 0);
      end else begin
        start = (mode == 3);
        in_valid = (mode == 2) ? ((cyc % 2) == 1) : 1'b1;
        out_ready = 1;
        if (mode == 1 && out_valid && !stalled) begin
          stalled = 1;
          stall_left = 5;
        end
        if (mode == 3 && out_valid && out_last &&
            !stalled) begin
          stalled = 1;
          stall_left = 2;
        end
        if (stall_left > 0) begin
          out_ready = 0;
          stall_left--;
        end
        @(negedge clk);
        if (win_en) acc++;
        if (out_valid && out_ready && out_last)
          hs_last = cyc;
        if (!out_ready && mode == 1) begin
          chk("stall_in_ready", 32'(in_ready), 0);
          chk("stall_win_en", 32'(win_en), 0);
          chk("stall_valid", 32'(out_valid), 1);
          chk("stall_row", 32'(out_row), 2);
          chk("stall_col", 32'(out_col), 2);
        end
        if (!out_ready && mode == 3) begin
          chk("drain_busy", 32'(busy), 1);
          chk("drain_in_ready", 32'(in_ready), 0);
          chk("drain_last", 32'(out_last), 1);
        end
      end
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL frame_timeout: got no frame_done, expected one (mode %0d)",
               mode);
    end
    start = 0;
    in_valid = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, cycs, w0, n;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_valid", 32'(out_valid), 0);
    rst_n = 1;
    @(posedge clk); #1;
    chk("idle_in_ready", 32'(in_ready), 0);
    chk("idle_fd", 32'(frame_done), 0);

    // Plain streaming frame
    push_default();
    start_frame();
    run_frame(0, acc, cycs);
    chk("t1_accepted", acc, 16);
    chk("t1_cycles", cycs, 17);
    chk("t1_windows", wins1, 4);
    @(posedge clk); #1;
    chk("t1_fd_pulse", 32'(frame_done), 0);
    chk("t1_busy", 32'(busy), 0);
    chk("t1_in_ready", 32'(in_ready), 0);

    // Downstream stall on the first window
    push_default();
    start_frame();
    run_frame(1, acc, cycs);
    chk("t2_accepted", acc, 16);
    chk("t2_cycles", cycs, 22);

    // in_valid toggling
    push_default();
    start_frame();
    run_frame(2, acc, cycs);
    chk("t3_accepted", acc, 16);
    chk("t3_cycles", cycs, 33);

    // start held through RUN/DRAIN, then back-to-back frame
    push_default();
    start_frame();
    run_frame(3, acc, cycs);
    chk("t4_cycles", cycs, 19);
    start = 1;
    @(posedge clk); #1;
    start = 0;
    chk("t4_restart_busy", 32'(busy), 1);
    chk("t4_restart_fd", 32'(frame_done), 0);
    push_default();
    run_frame(0, acc, cycs);
    chk("t4b_accepted", acc, 16);
    chk("t4b_empty", q1.size(), 0);

    // Reset in the middle of a frame
    start_frame();
    n = 0;
    for (int i = 0; i < 50 && n < 7; i++) begin
      @(posedge clk); #1;
      start = 0;
      in_valid = 1;
      out_ready = 1;
      @(negedge clk);
      if (win_en) n++;
    end
    @(posedge clk); #1;
    in_valid = 0;
    chk("t5_pre_row", 32'(out_row), 1);
    chk("t5_pre_col", 32'(out_col), 2);
    in_valid = 1;
    #1 rst_n = 0;
    #1;
    chk("t5_busy", 32'(busy), 0);
    chk("t5_in_ready", 32'(in_ready), 0);
    chk("t5_win_en", 32'(win_en), 0);
    chk("t5_valid", 32'(out_valid), 0);
    chk("t5_last", 32'(out_last), 0);
    chk("t5_fd", 32'(frame_done), 0);
    chk("t5_row", 32'(out_row), 0);
    chk("t5_col", 32'(out_col), 0);
    @(posedge clk); #1;
    rst_n = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t5_post_in_ready", 32'(in_ready), 0);
      chk("t5_post_win_en", 32'(win_en), 0);
    end
    in_valid = 0;
    w0 = wins1;
    push_default();
    start_frame();
    run_frame(0, acc, cycs);
    chk("t5_windows", wins1 - w0, 4);
    chk("t5_accepted", acc, 16);

    // 2x2 window over 5x3 frame
    for (int r = 1; r <= 2; r++)
      for (int c = 1; c <= 4; c++)
        push2(r, c, (r == 2 && c == 4));
    @(posedge clk); #1;
    start2 = 1;
    @(posedge clk); #1;
    start2 = 0;
    in_valid2 = 1;
    out_ready2 = 1;
    n = 0;
    acc = 0;
    for (int i = 0; i < 100 && n == 0; i++) begin
      @(negedge clk);
      if (win_en2) acc++;
      @(posedge clk); #1;
      if (frame_done2) n = 1;
    end
    chk("t6_done", n, 1);
    chk("t6_accepted", acc, 15);
    chk("t6_windows", wins2, 8);
    chk("t6_empty", q2.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
